// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that shares one W-bit register among N requesters.
// Each grant lasts one cycle; a granted requester with we set loads its data.
module shared_reg_arbiter #(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         we,
  input  logic [N*W-1:0]       wdata,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         rdata,
  output logic [$clog2(N)-1:0] owner,
  output logic [7:0]           wr_count,
  output logic                 busy
);

  localparam int IW = $clog2(N);
  localparam logic [IW:0] N_W = (IW+1)'(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] pick;
  logic [2*N-1:0] req_rot;
  logic [W-1:0]  wd [N];

  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign wd[i] = wdata[i*W +: W];
  end

  // (a + b) mod N without a divider; b is always < N so one subtraction suffices.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input logic [IW:0] b);
    logic [IW:0] s;
    s = {1'b0, a} + b;
    if (s >= N_W) s = s - N_W;
    return s[IW-1:0];
  endfunction

  // Rotate requests so bit k corresponds to requester (ptr + k) mod N; scanning
  // from the top down lets the lowest rotated index, i.e. nearest to ptr, win.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_rot = {req, req} >> ptr;
    pick    = ptr;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) pick = wrap_add(ptr, (IW+1)'(k));
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      ptr      <= '0;
      win      <= '0;
      gnt      <= '0;
      busy     <= 1'b0;
      rdata    <= '0;
      owner    <= '0;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            win   <= pick;
            gnt   <= N'(1) << pick;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          // A dropped request aborts the grant; we low makes it a read grant.
          if (req[win] && we[win]) begin
            rdata    <= wd[win];
            owner    <= win;
            wr_count <= wr_count + 8'd1;
          end
          ptr   <= wrap_add(win, (IW+1)'(1));
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: directed vector table, hand-written
// reset/wrap sequences, and random traffic against a behavioural model.
module tb_shared_reg_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N-1:0]   we;
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [W-1:0]   rdata;
  logic [1:0]     owner;
  logic [7:0]     wr_count;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;

  shared_reg_arbiter #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .wdata(wdata),
    .gnt(gnt), .rdata(rdata), .owner(owner), .wr_count(wr_count), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural model: -1 means no grant outstanding.
  int       m_ptr, m_win, m_owner;
  bit [7:0] m_reg, m_cnt;

  function automatic void model_reset();
    m_ptr = 0; m_win = -1; m_owner = 0; m_reg = 8'h00; m_cnt = 8'h00;
  endfunction

  function automatic void model_step(input logic [N-1:0] r, input logic [N-1:0] w,
                                     input logic [N*W-1:0] d);
    if (m_win < 0) begin
      for (int k = 0; k < N; k++) begin
        if (r[(m_ptr + k) % N]) begin
          m_win = (m_ptr + k) % N;
          break;
        end
      end
    end else begin
      if (r[m_win] && w[m_win]) begin
        m_reg   = d[m_win*W +: W];
        m_owner = m_win;
        m_cnt   = m_cnt + 8'd1;
      end
      m_ptr = (m_win + 1) % N;
      m_win = -1;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".gnt"},   32'(gnt),      (m_win < 0) ? 32'd0 : (32'd1 << m_win));
    check({tag, ".busy"},  32'(busy),     32'(m_win >= 0));
    check({tag, ".rdata"}, 32'(rdata),    32'(m_reg));
    check({tag, ".owner"}, 32'(owner),    32'(m_owner));
    check({tag, ".cnt"},   32'(wr_count), 32'(m_cnt));
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, return at the next negedge.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N*W-1:0] d);
    req = r; we = w; wdata = d;
    @(posedge clk);
    if (rst) model_step(r, w, d);
    @(negedge clk);
  endtask

  typedef struct {
    logic [N-1:0]   req;
    logic [N-1:0]   we;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [7:0]     rdata;
    logic [1:0]     owner;
    logic [7:0]     cnt;
    logic           busy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] r, input logic [3:0] w, input logic [31:0] d,
                     input logic [3:0] g, input logic [7:0] rd, input logic [1:0] o,
                     input logic [7:0] c, input logic b);
    vec_t v;
    v.req = r; v.we = w; v.wdata = d; v.gnt = g; v.rdata = rd; v.owner = o; v.cnt = c; v.busy = b;
    vecs.push_back(v);
  endtask

  initial begin
    // Round robin from reset: order 0,1,2,3,0 with an idle cycle between grants.
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0001, 8'h00, 2'd0, 8'd0, 1'b1);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0000, 8'h10, 2'd0, 8'd1, 1'b0);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0010, 8'h10, 2'd0, 8'd1, 1'b1);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0000, 8'h11, 2'd1, 8'd2, 1'b0);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0100, 8'h11, 2'd1, 8'd2, 1'b1);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0000, 8'h12, 2'd2, 8'd3, 1'b0);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b1000, 8'h12, 2'd2, 8'd3, 1'b1);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0000, 8'h13, 2'd3, 8'd4, 1'b0);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0001, 8'h13, 2'd3, 8'd4, 1'b1);
    add(4'b1111, 4'b1111, 32'h13121110, 4'b0000, 8'h10, 2'd0, 8'd5, 1'b0);
    // Single write from requester 2, then the request is dropped.
    add(4'b0100, 4'b0100, 32'h00A50000, 4'b0100, 8'h10, 2'd0, 8'd5, 1'b1);
    add(4'b0100, 4'b0100, 32'h00A50000, 4'b0000, 8'hA5, 2'd2, 8'd6, 1'b0);
    add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 8'hA5, 2'd2, 8'd6, 1'b0);
    // Abort: requester 1 drops req during its grant; next search starts at 2.
    add(4'b0010, 4'b0010, 32'h00007700, 4'b0010, 8'hA5, 2'd2, 8'd6, 1'b1);
    add(4'b0000, 4'b0010, 32'h00007700, 4'b0000, 8'hA5, 2'd2, 8'd6, 1'b0);
    add(4'b1110, 4'b0000, 32'h00000000, 4'b0100, 8'hA5, 2'd2, 8'd6, 1'b1);
    add(4'b0100, 4'b0000, 32'h00000000, 4'b0000, 8'hA5, 2'd2, 8'd6, 1'b0);
    // Read grant for requester 3: pulse with no write.
    add(4'b1000, 4'b0000, 32'hEE000000, 4'b1000, 8'hA5, 2'd2, 8'd6, 1'b1);
    add(4'b1000, 4'b0000, 32'hEE000000, 4'b0000, 8'hA5, 2'd2, 8'd6, 1'b0);
    add(4'b0000, 4'b0000, 32'h00000000, 4'b0000, 8'hA5, 2'd2, 8'd6, 1'b0);

    // Reset held for 10 ns with all requests high.
    rst = 1'b0; req = 4'b1111; we = 4'b1111; wdata = 32'hFFFFFFFF;
    model_reset();
    #1;
    check_model("reset_t1");
    check("reset_t1.gnt", 32'(gnt), 32'd0);
    @(negedge clk);
    check_model("reset_t10");
    check("reset_t10.rdata", 32'(rdata), 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].req, vecs[i].we, vecs[i].wdata);
      check($sformatf("vec%0d.gnt", i),   32'(gnt),      32'(vecs[i].gnt));
      check($sformatf("vec%0d.busy", i),  32'(busy),     32'(vecs[i].busy));
      check($sformatf("vec%0d.rdata", i), 32'(rdata),    32'(vecs[i].rdata));
      check($sformatf("vec%0d.owner", i), 32'(owner),    32'(vecs[i].owner));
      check($sformatf("vec%0d.cnt", i),   32'(wr_count), 32'(vecs[i].cnt));
    end

    // Reset during a grant to requester 0 (ptr is back at 0 here).
    cyc(4'b0001, 4'b0001, 32'h000000FF);
    check("midrst.gnt_before", 32'(gnt), 32'b0001);
    rst = 1'b0;
    model_reset();
    #1;
    check("midrst.gnt_async", 32'(gnt), 32'd0);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.rdata", 32'(rdata), 32'h00);
    check("midrst.cnt", 32'(wr_count), 32'd0);
    @(negedge clk);
    check("midrst.rdata_held", 32'(rdata), 32'h00);
    rst = 1'b1;
    cyc(4'b1111, 4'b0000, 32'h0);
    check("midrst.first_gnt", 32'(gnt), 32'b0001);
    cyc(4'b0000, 4'b0000, 32'h0);
    check_model("midrst.after");

    // Counter wrap: 256 writes from requester 0 starting at wr_count = 0.
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      cyc(4'b0001, 4'b0001, {24'h0, 8'(i) ^ 8'h5A});
      cyc(4'b0001, 4'b0001, {24'h0, 8'(i) ^ 8'h5A});
      check_model($sformatf("wrap%0d", i));
      if (i == 254) check("wrap.cnt255", 32'(wr_count), 32'd255);
    end
    cyc(4'b0000, 4'b0000, 32'h0);
    check("wrap.cnt0", 32'(wr_count), 32'd0);
    check("wrap.rdata", 32'(rdata), 32'hA5);
    check("wrap.owner", 32'(owner), 32'd0);

    // Random traffic, including aborts and read grants.
    for (int i = 0; i < 600; i++) begin
      cyc(4'($urandom), 4'($urandom), $urandom);
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
